// File: rtl/hs_npu_cmd_scheduler.sv
// Layer-command FIFO and round-robin dispatcher for a multi-core NPU.
// Optional per-core busy-cycle counters: define HS_NPU_SCHED_PERF_EN.
module hs_npu_cmd_scheduler #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned CMD_WIDTH = 256,
  parameter int unsigned CMD_DEPTH = 8,
  parameter int unsigned CNT_W     = $clog2(CMD_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [CMD_WIDTH-1:0]  cmd_data_i,
  input  logic                  cmd_barrier_i,
  input  logic                  flush_i,
  output logic [NUM_CORES-1:0]  core_exec_valid_o,
  input  logic [NUM_CORES-1:0]  core_exec_ready_i,
  output logic [CMD_WIDTH-1:0]  core_cmd_o,
  input  logic [NUM_CORES-1:0]  core_done_i,
  output logic [NUM_CORES-1:0]  core_busy_o,
  output logic [CNT_W-1:0]      queue_count_o,
  output logic [31:0]           completed_count_o,
  output logic                  idle_o,
  output logic                  err_o
`ifdef HS_NPU_SCHED_PERF_EN
  ,
  output logic [NUM_CORES*32-1:0] core_busy_cycles_o
`endif
);

  localparam int unsigned PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned GW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned ENT_W = CMD_WIDTH + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_BARRIER = 2'd2;

  logic [ENT_W-1:0]     mem [CMD_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [1:0]           state, state_nxt;
  logic [GW-1:0]        grant, last_grant, sel_idx;
  logic                 sel_found;
  logic [NUM_CORES-1:0] busy, grant_oh, done_ok, done_bad;
  logic [31:0]          done_cnt;
  logic [ENT_W-1:0]     head;
  logic                 full, empty, push, hs;
  int unsigned          cand;

  assign full      = (count == CNT_W'(CMD_DEPTH));
  assign empty     = (count == '0);
  assign push      = cmd_valid_i & cmd_ready_o;
  assign head      = mem[rd_ptr];
  assign grant_oh  = NUM_CORES'(1) << grant;
  assign hs        = (state == S_ISSUE) & |(core_exec_ready_i & grant_oh);
  assign done_ok   = core_done_i & busy;
  assign done_bad  = core_done_i & ~busy;

  assign cmd_ready_o       = ~full & ~flush_i;
  assign core_exec_valid_o = (state == S_ISSUE) ? grant_oh : '0;
  assign core_cmd_o        = (state == S_ISSUE) ? head[CMD_WIDTH-1:0] : '0;
  assign core_busy_o       = busy;
  assign queue_count_o     = count;
  assign idle_o            = empty & ~|busy & (state == S_IDLE);

  // Round-robin pick: first free core after the last grant, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      cand = int'(last_grant) + i + 1;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!sel_found && !busy[GW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = GW'(cand);
      end
    end
  end

  always_comb begin
    done_cnt = '0;
    for (int k = 0; k < int'(NUM_CORES); k++) begin
      done_cnt = done_cnt + 32'(done_ok[k]);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!flush_i && !empty) begin
          if (head[CMD_WIDTH] && |busy) state_nxt = S_BARRIER;
          else if (sel_found)           state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs) state_nxt = S_IDLE;
      end
      S_BARRIER: begin
        if (flush_i || ((busy & ~core_done_i) == '0)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant latched on entry to ISSUE; remembered after the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant      <= '0;
      last_grant <= GW'(NUM_CORES - 1);
    end else begin
      if (state == S_IDLE && state_nxt == S_ISSUE) grant <= sel_idx;
      if (hs) last_grant <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_barrier_i, cmd_data_i};
  end

  // FIFO pointers; a flush during ISSUE keeps only the head entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i && state != S_ISSUE) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= rd_ptr + PTR_W'(1);
      if (hs) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        count  <= '0;
      end else begin
        count  <= CNT_W'(1);
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (hs)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, hs})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy              <= '0;
      completed_count_o <= '0;
      err_o             <= 1'b0;
    end else begin
      busy              <= (busy & ~core_done_i) | (hs ? grant_oh : '0);
      completed_count_o <= completed_count_o + done_cnt;
      if (|done_bad) err_o <= 1'b1;
    end
  end

`ifdef HS_NPU_SCHED_PERF_EN
  // Saturating busy-cycle counter per core.
  for (genvar g = 0; g < int'(NUM_CORES); g++) begin : g_perf
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        core_busy_cycles_o[g*32 +: 32] <= '0;
      end else if (busy[g] && core_busy_cycles_o[g*32 +: 32] != 32'hFFFF_FFFF) begin
        core_busy_cycles_o[g*32 +: 32] <= core_busy_cycles_o[g*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hs_npu_cmd_scheduler.sv
// Directed bench for hs_npu_cmd_scheduler with two cores and a depth-8 queue.
module tb_hs_npu_cmd_scheduler;

  localparam int unsigned NC = 2;
  localparam int unsigned CW = 32;
  localparam int unsigned CD = 8;
  localparam int unsigned CN = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_barrier, flush;
  logic [CW-1:0] cmd_data, core_cmd;
  logic [NC-1:0] exec_valid, exec_ready, done, busy;
  logic [CN-1:0] qcount;
  logic [31:0]   completed;
  logic          idle, err;
`ifdef HS_NPU_SCHED_PERF_EN
  logic [NC*32-1:0] busy_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hs_npu_cmd_scheduler #(
    .NUM_CORES(NC), .CMD_WIDTH(CW), .CMD_DEPTH(CD), .CNT_W(CN)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cmd_valid_i       (cmd_valid),
    .cmd_ready_o       (cmd_ready),
    .cmd_data_i        (cmd_data),
    .cmd_barrier_i     (cmd_barrier),
    .flush_i           (flush),
    .core_exec_valid_o (exec_valid),
    .core_exec_ready_i (exec_ready),
    .core_cmd_o        (core_cmd),
    .core_done_i       (done),
    .core_busy_o       (busy),
    .queue_count_o     (qcount),
    .completed_count_o (completed),
    .idle_o            (idle),
    .err_o             (err)
`ifdef HS_NPU_SCHED_PERF_EN
    ,
    .core_busy_cycles_o(busy_cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_barrier = 1'b0; flush = 1'b0;
    cmd_data = '0; exec_ready = '0; done = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst_valid", 64'(exec_valid), 64'd0);
    check("rst_cmd", 64'(core_cmd), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_qcount", 64'(qcount), 64'd0);
    check("rst_completed", 64'(completed), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_ready", 64'(cmd_ready), 64'd1);

    // Back-to-back push of A, B, C with both cores ready
    exec_ready = 2'b11;
    cmd_valid = 1'b1; cmd_data = 32'hA000_0001; tick();
    check("t1_c1_valid", 64'(exec_valid), 64'd0);
    cmd_data = 32'hB000_0002; tick();
    check("t1_c2_valid", 64'(exec_valid), 64'h1);
    check("t1_c2_cmd", 64'(core_cmd), 64'hA000_0001);
    cmd_data = 32'hC000_0003; tick();
    cmd_valid = 1'b0;
    check("t1_c3_valid", 64'(exec_valid), 64'd0);
    check("t1_c3_busy", 64'(busy), 64'h1);
    check("t1_c3_qcount", 64'(qcount), 64'd2);
    tick();
    check("t1_c4_valid", 64'(exec_valid), 64'h2);
    check("t1_c4_cmd", 64'(core_cmd), 64'hB000_0002);
    tick();
    check("t1_c5_busy", 64'(busy), 64'h3);
    check("t1_c5_qcount", 64'(qcount), 64'd1);
    check("t1_c5_valid", 64'(exec_valid), 64'd0);
    check("t1_c5_cmd", 64'(core_cmd), 64'd0);
    repeat (5) tick();
    done = 2'b01; tick(); done = '0;
    check("t1_c11_busy", 64'(busy), 64'h2);
    check("t1_c11_completed", 64'(completed), 64'd1);
    tick();
    check("t1_c12_valid", 64'(exec_valid), 64'h1);
    check("t1_c12_cmd", 64'(core_cmd), 64'hC000_0003);
    tick();
    check("t1_c13_busy", 64'(busy), 64'h3);
    check("t1_c13_qcount", 64'(qcount), 64'd0);

    // Barrier command waits for core0 to drain
    done = 2'b10; tick(); done = '0;
    check("t2_busy", 64'(busy), 64'h1);
    check("t2_completed", 64'(completed), 64'd2);
    cmd_valid = 1'b1; cmd_barrier = 1'b1; cmd_data = 32'hD000_0004; tick();
    cmd_valid = 1'b0; cmd_barrier = 1'b0;
    tick();
    check("t2_wait_valid0", 64'(exec_valid), 64'd0);
    check("t2_wait_qcount", 64'(qcount), 64'd1);
    tick();
    check("t2_wait_valid1", 64'(exec_valid), 64'd0);
    check("t2_wait_idle", 64'(idle), 64'd0);
    done = 2'b01; tick(); done = '0;
    check("t2_release_busy", 64'(busy), 64'd0);
    check("t2_release_completed", 64'(completed), 64'd3);
    check("t2_release_valid", 64'(exec_valid), 64'd0);
    tick();
    check("t2_issue_valid", 64'(exec_valid), 64'h2);
    check("t2_issue_cmd", 64'(core_cmd), 64'hD000_0004);
    tick();
    check("t2_after_busy", 64'(busy), 64'h2);
    check("t2_after_qcount", 64'(qcount), 64'd0);

    // Core0 stalls the handshake; request and data must hold
    exec_ready = 2'b10;
    cmd_valid = 1'b1; cmd_data = 32'hE000_0005; tick();
    cmd_data = 32'hF000_0006; tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_valid", 64'(exec_valid), 64'h1);
      check("t3_stall_cmd", 64'(core_cmd), 64'hE000_0005);
      check("t3_stall_qcount", 64'(qcount), 64'd2);
      tick();
    end
    exec_ready = 2'b11; tick();
    check("t3_hs_qcount", 64'(qcount), 64'd1);
    check("t3_hs_busy", 64'(busy), 64'h3);
    check("t3_hs_valid", 64'(exec_valid), 64'd0);
    done = 2'b11; tick(); done = '0;
    check("t3_dual_done_busy", 64'(busy), 64'd0);
    check("t3_dual_done_completed", 64'(completed), 64'd5);
    tick();
    check("t3_f_valid", 64'(exec_valid), 64'h2);
    check("t3_f_cmd", 64'(core_cmd), 64'hF000_0006);
    tick();
    check("t3_f_busy", 64'(busy), 64'h2);
    done = 2'b10; tick(); done = '0;
    check("t3_end_completed", 64'(completed), 64'd6);
    check("t3_end_idle", 64'(idle), 64'd1);

    // Fill queue with no core accepting; ninth push is dropped
    exec_ready = 2'b00;
    for (int i = 0; i < 9; i++) begin
      cmd_valid = 1'b1; cmd_data = 32'h6000_0000 + 32'(i); tick();
      if (i == 7) begin
        check("t4_full_ready", 64'(cmd_ready), 64'd0);
        check("t4_full_qcount", 64'(qcount), 64'd8);
      end
    end
    cmd_valid = 1'b0;
    check("t4_ninth_qcount", 64'(qcount), 64'd8);
    check("t4_head_valid", 64'(exec_valid), 64'h1);
    check("t4_head_cmd", 64'(core_cmd), 64'h6000_0000);

    // Flush during ISSUE keeps only the head
    flush = 1'b1; #1;
    check("t5_flush_ready", 64'(cmd_ready), 64'd0);
    tick(); flush = 1'b0;
    check("t5_flush_qcount", 64'(qcount), 64'd1);
    check("t5_flush_valid", 64'(exec_valid), 64'h1);
    check("t5_flush_cmd", 64'(core_cmd), 64'h6000_0000);
    exec_ready = 2'b11; tick();
    check("t5_hs_qcount", 64'(qcount), 64'd0);
    check("t5_hs_busy", 64'(busy), 64'h1);
    tick();
    check("t5_drained_valid", 64'(exec_valid), 64'd0);

    // Flush while waiting on a barrier
    cmd_valid = 1'b1; cmd_barrier = 1'b1; cmd_data = 32'h7000_0001; tick();
    cmd_barrier = 1'b0; cmd_data = 32'h7000_0002; tick();
    cmd_valid = 1'b0;
    check("t5b_qcount", 64'(qcount), 64'd2);
    check("t5b_valid", 64'(exec_valid), 64'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    check("t5b_flush_qcount", 64'(qcount), 64'd0);
    tick();
    check("t5b_post_valid", 64'(exec_valid), 64'd0);
    check("t5b_post_idle", 64'(idle), 64'd0);
    done = 2'b01; tick(); done = '0;
    check("t5b_busy", 64'(busy), 64'd0);
    check("t5b_completed", 64'(completed), 64'd7);
    check("t5b_idle", 64'(idle), 64'd1);

    // Spurious done on an idle core
    done = 2'b10; tick(); done = '0;
    check("t6_err", 64'(err), 64'd1);
    check("t6_completed", 64'(completed), 64'd7);
    tick();
    check("t6_err_sticky", 64'(err), 64'd1);

`ifdef HS_NPU_SCHED_PERF_EN
    cmd_valid = 1'b1; cmd_data = 32'h8000_0001; tick();
    cmd_valid = 1'b0;
    tick(); tick();
    check("t6_perf_busy", 64'(busy), 64'h2);
    repeat (6) tick();
    done = 2'b10; tick(); done = '0;
    check("t6_perf_cycles", 64'(busy_cycles[63:32]), 64'd7);
`endif

    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    check("t7_rst_err", 64'(err), 64'd0);
    check("t7_rst_completed", 64'(completed), 64'd0);
    check("t7_rst_idle", 64'(idle), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hs_npu_cmd_scheduler.md
Name: hs_npu_cmd_scheduler

Overview:
Layer-command queue and dispatcher for a multi-core NPU. The CPU pushes layer commands (packed dims, flags, addresses) into a FIFO. The block issues each command to one of NUM_CORES hs_npu-style inference cores through their exec_valid/exec_ready handshake, chosen round-robin among idle cores. It tracks per-core busy state, honours barrier commands and counts completions.

Parameters:
NUM_CORES, 4, number of NPU cores served (1..16)
CMD_WIDTH, 256, bits per packed layer command
CMD_DEPTH, 8, command FIFO entries (power of 2, >=2)
CNT_W, $clog2(CMD_DEPTH+1), width of the queue occupancy count

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
cmd_valid_i  input  1  CPU command valid
cmd_ready_o  output  1  FIFO can accept a command
cmd_data_i  input  CMD_WIDTH  packed layer command
cmd_barrier_i  input  1  command must wait until all cores are idle before issue
flush_i  input  1  discard queued commands
core_exec_valid_o  output  NUM_CORES  one-hot issue request
core_exec_ready_i  input  NUM_CORES  core accepts a command
core_cmd_o  output  CMD_WIDTH  command broadcast to all cores
core_done_i  input  NUM_CORES  1-cycle completion pulse per core
core_busy_o  output  NUM_CORES  per-core busy flags
queue_count_o  output  CNT_W  FIFO occupancy
completed_count_o  output  32  total valid completions, wraps modulo 2^32
idle_o  output  1  FIFO empty, no core busy, FSM in IDLE
err_o  output  1  sticky: done_i seen on a non-busy core

Behaviour:
- Reset (rst_n low at a clk edge):
  - FIFO empty; FSM in IDLE; last_grant = NUM_CORES-1.
  - Outputs: core_exec_valid_o=0, core_cmd_o=0, core_busy_o=0, queue_count_o=0, completed_count_o=0, err_o=0, idle_o=1.
  - cmd_ready_o=1 after reset.
  - Reset mid-ISSUE drops the request immediately.
- FIFO:
  - Push on cmd_valid_i & cmd_ready_o. Each entry stores {barrier, data}.
  - cmd_ready_o = !full & !flush_i. A push while ready is low is ignored.
  - Pop only on an issue handshake.
  - Push and pop in the same cycle are allowed when neither full nor empty; occupancy is unchanged.
- FSM states IDLE, ISSUE, BARRIER_WAIT:
  - IDLE, FIFO non-empty, head barrier=1 and any core busy: go to BARRIER_WAIT.
  - IDLE otherwise, with any core free: latch grant = first non-busy core scanning from (last_grant+1) mod NUM_CORES upward with wrap, then go to ISSUE. If no core is free, stay in IDLE.
  - ISSUE:
    - core_exec_valid_o[grant]=1 and core_cmd_o=head data; both held stable until core_exec_ready_i[grant]=1. No retraction.
    - On the handshake: pop, set busy[grant], last_grant=grant, go to IDLE.
  - BARRIER_WAIT: go to IDLE when all busy bits are 0, including busy bits cleared by a done in the same cycle.
- Latency:
  - Command pushed at cycle N with the FIFO previously empty and a core free: exec_valid is asserted in cycle N+2.
  - Sustained issue rate: one command per 2 cycles.
- Busy tracking:
  - core_done_i[k] with busy[k]=1: clear busy[k] and increment completed_count_o. Multiple dones in one cycle add their popcount.
  - core_done_i[k] with busy[k]=0: ignored, and err_o is set (sticky until reset).
  - A done on core j and an issue to core k≠j in the same cycle are both honoured.
  - A core freed by done in cycle N is eligible for the IDLE selection in cycle N+1.
- Flush:
  - flush_i in IDLE or BARRIER_WAIT: FIFO emptied next cycle; FSM goes to IDLE.
  - flush_i in ISSUE: the head entry is kept and its handshake completes; all other entries are dropped.
  - Busy flags and counters are unaffected by flush.
- core_cmd_o is 0 whenever no core_exec_valid_o bit is set.

Optional Feature:
HS_NPU_SCHED_PERF_EN:
- Defined: adds output core_busy_cycles_o (NUM_CORES x 32 bits).
  - Per-core counter increments every cycle busy[k]=1 and saturates at 2^32-1.
  - Reset to 0; flush does not clear it.
- Undefined: the port and the counters are absent. All other behaviour is identical.

Test Plan:
1. NUM_CORES=2, all ready=1, push A,B,C back-to-back.
   - A is issued to core0 at cycle 2 and B to core1 at cycle 4.
   - C waits; core0 done at cycle 10 → C is issued to core0 at cycle 12.
   - completed_count_o=1 after cycle 10.
2. Core0 busy; push barrier command D.
   - FSM stays in BARRIER_WAIT with exec_valid low.
   - core0 done at cycle 20 → D is issued to core1 (round-robin after last_grant=0) at cycle 22.
3. core_exec_ready_i[0] low for 5 cycles during ISSUE.
   - core_exec_valid_o[0] and core_cmd_o are stable all 5 cycles.
   - Pop happens only on the handshake cycle; queue_count_o drops by 1 then.
4. CMD_DEPTH=8, all ready low, push 9 commands.
   - cmd_ready_o goes low after the 8th push; queue_count_o=8; the 9th command is not stored.
5. Queue holds 5 entries, ISSUE pending; assert flush_i, then ready.
   - The head is issued; queue_count_o=0 afterwards; cmd_ready_o is low during the flush cycle.
6. core_done_i[1] pulse with core1 idle → err_o=1 sticky and completed_count_o unchanged. With HS_NPU_SCHED_PERF_EN, a core busy for 7 cycles → core_busy_cycles_o[k]=7.
